div_restoring_50x24: RTL and testbench

DIV_RESTORING_50X24 -- requirements
Module: div_restoring_50x24

---
 rtl/div_restoring_50x24.sv | 186 ++++++++++++++++++
 tb/tb_div_restoring_50x24.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/div_restoring_50x24.sv
// div_restoring_50x24
// Unsigned 50-by-24 radix-2 restoring divider that retires one quotient bit
// per clock. A start accepted in IDLE either finishes at once (divide by zero
// or quotient overflow) or runs 26 iterations in BUSY. The block then spends
// one cycle in DONE, where ready is high.
//
// Ports
//   clk    rising-edge clock for all state
//   rst    synchronous reset, active-high
//   start  request pulse, sampled only in IDLE
//   a      50-bit unsigned dividend, latched when start is accepted
//   b      24-bit unsigned divisor, latched when start is accepted
//   q      26-bit quotient, held until the next completion
//   r      24-bit remainder, held until the next completion
//   busy   high while an iteration sequence is in progress
//   ready  one-cycle pulse when q, r, ovf and dbz are valid
//   ovf    quotient does not fit in 26 bits, held with the result
//   dbz    divide by zero, held with the result
module div_restoring_50x24 (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [49:0] a,
    input  logic [23:0] b,
    output logic [25:0] q,
    output logic [23:0] r,
    output logic        busy,
    output logic        ready,
    output logic        ovf,
    output logic        dbz
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [4:0] LAST_ITER = 5'd25;

    state_e      state_q, state_d;
    logic [23:0] pr_q, pr_d;      // partial remainder
    logic [25:0] qs_q, qs_d;      // dividend low bits shifting out, quotient bits shifting in
    logic [23:0] div_q, div_d;    // latched divisor
    logic [4:0]  cnt_q, cnt_d;    // iteration index, 0..25
    logic [25:0] quo_q, quo_d;
    logic [23:0] rem_q, rem_d;
    logic        ovf_q, ovf_d;
    logic        dbz_q, dbz_d;
    logic        busy_q, busy_d;
    logic        ready_q, ready_d;

    logic [23:0] pr_shift_s;
    logic        take_s;
    logic [23:0] trial_s;
    logic [23:0] pr_iter_s;
    logic [25:0] qs_iter_s;

    // One restoring step: shift in the next dividend bit and subtract if the divisor fits.
    // pr_q[23] is the bit shifted out of pr_shift_s. It takes part in the compare
    // so that the 25-bit shifted value is tested against the divisor. The
    // difference itself always fits in 24 bits, because PR < b holds.
    always_comb begin
        pr_shift_s = {pr_q[22:0], qs_q[25]};
        take_s     = ({pr_q[23], pr_shift_s} >= {1'b0, div_q});
        trial_s    = pr_shift_s - div_q;
        if (take_s) begin
            pr_iter_s = trial_s;
        end else begin
            pr_iter_s = pr_shift_s;
        end
        qs_iter_s = {qs_q[24:0], take_s};
    end

    // State register and datapath registers, with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            pr_q    <= 24'd0;
            qs_q    <= 26'd0;
            div_q   <= 24'd0;
            cnt_q   <= 5'd0;
            quo_q   <= 26'd0;
            rem_q   <= 24'd0;
            ovf_q   <= 1'b0;
            dbz_q   <= 1'b0;
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pr_q    <= pr_d;
            qs_q    <= qs_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            ovf_q   <= ovf_d;
            dbz_q   <= dbz_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
        end
    end

    // Next-state and datapath update logic.
    always_comb begin
        state_d = state_q;
        pr_d    = pr_q;
        qs_d    = qs_q;
        div_d   = div_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        ovf_d   = ovf_q;
        dbz_d   = dbz_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    div_d = b;
                    pr_d  = a[49:26];
                    qs_d  = a[25:0];
                    cnt_d = 5'd0;
                    if (b == 24'd0) begin
                        state_d = ST_DONE;
                        dbz_d   = 1'b1;
                        ovf_d   = 1'b0;
                        quo_d   = 26'd0;
                        rem_d   = 24'd0;
                    end else if (a[49:26] >= b) begin
                        // The upper dividend half must be below b, or the quotient needs more than 26 bits.
                        state_d = ST_DONE;
                        dbz_d   = 1'b0;
                        ovf_d   = 1'b1;
                        quo_d   = 26'd0;
                        rem_d   = 24'd0;
                    end else begin
                        state_d = ST_BUSY;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                pr_d = pr_iter_s;
                qs_d = qs_iter_s;
                if (cnt_q == LAST_ITER) begin
                    state_d = ST_DONE;
                    cnt_d   = 5'd0;
                    quo_d   = qs_iter_s;
                    rem_d   = pr_iter_s;
                    ovf_d   = 1'b0;
                    dbz_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output decode. It is taken from the next state, so busy and ready are registered.
    always_comb begin
        busy_d  = 1'b0;
        ready_d = 1'b0;
        case (state_d)
            ST_BUSY: busy_d  = 1'b1;
            ST_DONE: ready_d = 1'b1;
            default: begin
                busy_d  = 1'b0;
                ready_d = 1'b0;
            end
        endcase
    end

    assign q     = quo_q;
    assign r     = rem_q;
    assign ovf   = ovf_q;
    assign dbz   = dbz_q;
    assign busy  = busy_q;
    assign ready = ready_q;

endmodule

// File: tb/tb_div_restoring_50x24.sv
module tb_div_restoring_50x24;

    logic        clk;
    logic        rst;
    logic        start;
    logic [49:0] a;
    logic [23:0] b;
    logic [25:0] q;
    logic [23:0] r;
    logic        busy;
    logic        ready;
    logic        ovf;
    logic        dbz;

    int n_vec = 0;
    int n_err = 0;

    div_restoring_50x24 dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .q     (q),
        .r     (r),
        .busy  (busy),
        .ready (ready),
        .ovf   (ovf),
        .dbz   (dbz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // The caller is at a negedge with the DUT in IDLE. The task returns at a negedge with the DUT back in IDLE.
    task automatic do_op(input string tag, input logic [49:0] av, input logic [23:0] bv, input bit poke);
        longint unsigned au, bu, eq, er;
        int elat, enb, j, nb;
        bit eovf, edbz;
        au = longint'(av);
        bu = longint'(bv);
        eovf = 1'b0; edbz = 1'b0; eq = 0; er = 0;
        if (bu == 0) begin
            edbz = 1'b1; elat = 0; enb = 0;
        end else if ((au >> 26) >= bu) begin
            eovf = 1'b1; elat = 0; enb = 0;
        end else begin
            eq = au / bu; er = au % bu; elat = 26; enb = 26;
        end
        a = av; b = bv; start = 1'b1;
        @(negedge clk);                 // edge N has passed
        start = 1'b0;
        a = {$urandom, $urandom};       // inputs changing after acceptance must not matter
        b = 24'($urandom);
        j = 0; nb = 0;
        while (ready !== 1'b1 && j < 40) begin
            if (busy === 1'b1) nb++;
            if (poke && j == 5) begin
                start = 1'b1; a = 50'd9; b = 24'd2;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            j++;
        end
        start = 1'b0;
        chk({tag, ".latency"}, 64'(j), 64'(elat));
        chk({tag, ".busy_cycles"}, 64'(nb), 64'(enb));
        chk({tag, ".busy_at_ready"}, 64'(busy), 64'd0);
        chk({tag, ".q"}, 64'(q), eq);
        chk({tag, ".r"}, 64'(r), er);
        chk({tag, ".ovf"}, 64'(ovf), 64'(eovf));
        chk({tag, ".dbz"}, 64'(dbz), 64'(edbz));
        if (!eovf && !edbz) begin
            chk({tag, ".identity"}, 64'(q) * bu + 64'(r), au);
        end else begin
            chk({tag, ".identity_skip"}, 64'(ready), 64'd1);
        end
        @(negedge clk);
        chk({tag, ".ready_one_cycle"}, 64'(ready), 64'd0);
        chk({tag, ".q_held"}, 64'(q), eq);
        chk({tag, ".r_held"}, 64'(r), er);
        chk({tag, ".idle_busy"}, 64'(busy), 64'd0);
    endtask

    initial begin
        logic [23:0] rb;
        logic [23:0] rhi;
        logic [25:0] rlo;
        rst = 1'b1; start = 1'b0; a = 50'd0; b = 24'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst.q", 64'(q), 64'd0);
        chk("rst.r", 64'(r), 64'd0);
        chk("rst.busy", 64'(busy), 64'd0);
        chk("rst.ready", 64'(ready), 64'd0);
        chk("rst.ovf", 64'(ovf), 64'd0);
        chk("rst.dbz", 64'(dbz), 64'd0);
        rst = 1'b0;

        do_op("maxprod", 50'h3FFFFFB000001, 24'hFFFFFF, 1'b0);
        do_op("maxprod_r5", 50'h3FFFFFB000006, 24'hFFFFFF, 1'b0);
        do_op("a100_b7_poke", 50'd100, 24'd7, 1'b1);
        do_op("dbz", 50'h1234, 24'd0, 1'b0);
        do_op("ovf", 50'h4000000, 24'd1, 1'b0);
        do_op("ovf_eq", 50'h3FFFFFC000000, 24'hFFFFFF, 1'b0);
        do_op("zero_dividend", 50'd0, 24'd13, 1'b0);

        // Reset during BUSY: start at edge N, then assert rst for edge N+10.
        a = 50'd100; b = 24'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort.q", 64'(q), 64'd0);
        chk("abort.r", 64'(r), 64'd0);
        chk("abort.busy", 64'(busy), 64'd0);
        chk("abort.ready", 64'(ready), 64'd0);
        chk("abort.ovf", 64'(ovf), 64'd0);
        chk("abort.dbz", 64'(dbz), 64'd0);
        rst = 1'b0;
        do_op("after_abort", 50'd50, 24'd5, 1'b0);

        for (int k = 0; k < 10; k++) begin
            if (k < 3) rb = 24'($urandom_range(1, 15));
            else rb = 24'($urandom_range(1, 32'hFFFFFF));
            if (k == 3 || k == 7) rhi = 24'($urandom);
            else rhi = 24'($urandom % rb);
            rlo = 26'($urandom);
            do_op($sformatf("rand%0d", k), {rhi, rlo}, rb, (k % 2) == 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
